// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
//   Shared definitions for the SRAM controller slice:
//     state_t     - controller states (IDLE, ACC, TURN, RESP)
//     WAIT_W      - width of the wait-state counter (0..15 extra cycles)
//     HALF_LO/HI  - half-select values (low half lives at the even address)
//     half_lanes  - byte-enable pair belonging to one half of a word
//     first_half  - half at which an access starts
//     needs_high  - whether the high half has to be accessed at all
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_TURN = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Byte enables {upper, lower} of the selected half.
  function automatic logic [1:0] half_lanes(input logic [3:0] be, input logic half);
    return (half == HALF_HI) ? be[3:2] : be[1:0];
  endfunction

  // A write touching no low-half byte starts straight at the high half.
  function automatic logic first_half(input logic we, input logic [3:0] be);
    return (we && (be[1:0] == 2'b00)) ? HALF_HI : HALF_LO;
  endfunction

  // Reads always fetch the whole word; writes only where bytes are enabled.
  function automatic logic needs_high(input logic we, input logic [3:0] be);
    return !we || (be[3:2] != 2'b00);
  endfunction

endpackage

// File: rtl/sram_io_buf.sv
// ---------------------------------------------------------------------------
// sram_io_buf
//   Tristate pad for the bidirectional SRAM data bus. Keeping the inout in
//   its own small module isolates the only tristate in the design.
//   Ports:
//     dout  in   DATA_W  value driven onto the pad when oe is high
//     oe    in   1       output enable (1 = drive, 0 = high-Z)
//     din   out  DATA_W  value currently seen on the pad
//     pad   inout DATA_W SRAM data bus
// ---------------------------------------------------------------------------
module sram_io_buf #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] dout,
  input  logic              oe,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] pad
);

  assign pad = oe ? dout : {DATA_W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//   Bridges a 32-bit valid/ready word bus to an asynchronous 16-bit SRAM.
//   Each word request becomes up to two halfword SRAM cycles (low half at
//   the even address first). Every half is WAIT+1 access cycles followed by
//   one turnaround cycle, then a single RESP cycle pulses resp_valid.
//   All SRAM strobes, the SRAM address and the bus driver enable are
//   registered, so the pins never glitch.
//   Ports:
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     req_valid/ready  request handshake; ready is high only in IDLE
//     req_we           1 = write, 0 = read
//     req_addr         word address (ADDR_W-1 bits)
//     req_be           byte enables for writes, bit0 = byte[7:0]
//     req_wdata        write data
//     resp_valid       one-cycle completion pulse (reads and writes)
//     resp_rdata       read data, held until the next read completes
//     sram_addr        halfword address {word, half}
//     sram_ce_n/oe_n/we_n/ub_n/lb_n   active-low SRAM strobes
//     sram_data        bidirectional SRAM data bus
// ---------------------------------------------------------------------------
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-2:0]   req_addr,
  input  logic [3:0]          req_be,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic [2*DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n,
  inout  wire  [DATA_W-1:0]   sram_data
);

  localparam logic [WAIT_W-1:0] RD_CNT = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_CNT = WAIT_W'(WR_WAIT);

  // Control state
  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   cnt_reg, cnt_next;
  logic                half_reg, half_next;

  // Latched request
  logic                we_reg, we_next;
  logic [ADDR_W-2:0]   addr_reg, addr_next;
  logic [3:0]          be_reg, be_next;
  logic [2*DATA_W-1:0] wdata_reg, wdata_next;

  // Read assembly buffer (both halves) and registered outputs
  logic [2*DATA_W-1:0] rdata_buf_reg;
  logic [2*DATA_W-1:0] resp_rdata_reg, resp_rdata_next;
  logic                resp_valid_reg, resp_valid_next;
  logic                req_ready_reg, req_ready_next;
  logic [ADDR_W-1:0]   sram_addr_reg, sram_addr_next;
  logic                ce_n_reg, ce_n_next;
  logic                oe_n_reg, oe_n_next;
  logic                we_n_reg, we_n_next;
  logic                ub_n_reg, ub_n_next;
  logic                lb_n_reg, lb_n_next;
  logic                drv_reg, drv_next;
  logic [DATA_W-1:0]   dout_reg, dout_next;

  logic [DATA_W-1:0]   din;
  logic                acc_next;
  logic [1:0]          lanes_next;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    half_next  = half_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;

    case (state_reg)
      ST_IDLE: begin
        // req_ready is high exactly in IDLE, so req_valid alone accepts.
        if (req_valid) begin
          we_next    = req_we;
          addr_next  = req_addr;
          be_next    = req_be;
          wdata_next = req_wdata;
          half_next  = first_half(req_we, req_be);
          if (req_we && (req_be == 4'b0000)) begin
            // Nothing to write: acknowledge without touching the SRAM.
            state_next = ST_RESP;
          end else begin
            state_next = ST_ACC;
            cnt_next   = req_we ? WR_CNT : RD_CNT;
          end
        end
      end

      ST_ACC: begin
        if (cnt_reg == '0) begin
          state_next = ST_TURN;
        end else begin
          cnt_next = cnt_reg - WAIT_W'(1);
        end
      end

      ST_TURN: begin
        if ((half_reg == HALF_LO) && needs_high(we_reg, be_reg)) begin
          half_next  = HALF_HI;
          state_next = ST_ACC;
          cnt_next   = we_reg ? WR_CNT : RD_CNT;
        end else begin
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state, so the registered pins line up
  // exactly with the state they belong to.
  // -------------------------------------------------------------------------
  always_comb begin
    acc_next   = (state_next == ST_ACC);
    // Reads enable both byte lanes; writes only the enabled ones.
    lanes_next = we_next ? half_lanes(be_next, half_next) : 2'b11;

    ce_n_next  = ~acc_next;
    oe_n_next  = ~(acc_next & ~we_next);
    we_n_next  = ~(acc_next & we_next);
    ub_n_next  = ~(acc_next & lanes_next[1]);
    lb_n_next  = ~(acc_next & lanes_next[0]);

    // The address is held outside ACC so it stays stable through turnaround.
    sram_addr_next = acc_next ? {addr_next, half_next} : sram_addr_reg;

    // Write data stays on the bus through TURN for hold time.
    drv_next  = we_next & (acc_next | (state_next == ST_TURN));
    dout_next = (half_next == HALF_HI) ? wdata_next[2*DATA_W-1:DATA_W]
                                       : wdata_next[DATA_W-1:0];

    resp_valid_next = (state_next == ST_RESP);
    resp_rdata_next = ((state_next == ST_RESP) && !we_next) ? rdata_buf_reg
                                                            : resp_rdata_reg;
    req_ready_next  = (state_next == ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      half_reg       <= HALF_LO;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      be_reg         <= '0;
      wdata_reg      <= '0;
      resp_rdata_reg <= '0;
      resp_valid_reg <= 1'b0;
      req_ready_reg  <= 1'b1;
      sram_addr_reg  <= '0;
      ce_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
      we_n_reg       <= 1'b1;
      ub_n_reg       <= 1'b1;
      lb_n_reg       <= 1'b1;
      drv_reg        <= 1'b0;
      dout_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      half_reg       <= half_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      be_reg         <= be_next;
      wdata_reg      <= wdata_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_valid_reg <= resp_valid_next;
      req_ready_reg  <= req_ready_next;
      sram_addr_reg  <= sram_addr_next;
      ce_n_reg       <= ce_n_next;
      oe_n_reg       <= oe_n_next;
      we_n_reg       <= we_n_next;
      ub_n_reg       <= ub_n_next;
      lb_n_reg       <= lb_n_next;
      drv_reg        <= drv_next;
      dout_reg       <= dout_next;
    end
  end

  // Read data is captured at the end of the last access cycle of each half,
  // giving the SRAM the full WAIT+1 cycles of access time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_buf_reg <= '0;
    end else if ((state_reg == ST_ACC) && (cnt_reg == '0) && !we_reg) begin
      if (half_reg == HALF_HI) begin
        rdata_buf_reg[2*DATA_W-1:DATA_W] <= din;
      end else begin
        rdata_buf_reg[DATA_W-1:0] <= din;
      end
    end
  end

  sram_io_buf #(
    .DATA_W (DATA_W)
  ) u_io_buf (
    .dout (dout_reg),
    .oe   (drv_reg),
    .din  (din),
    .pad  (sram_data)
  );

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign sram_addr  = sram_addr_reg;
  assign sram_ce_n  = ce_n_reg;
  assign sram_oe_n  = oe_n_reg;
  assign sram_we_n  = we_n_reg;
  assign sram_ub_n  = ub_n_reg;
  assign sram_lb_n  = lb_n_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//   Bench for sram_ctrl with an asynchronous SRAM model on the pins, a
//   word-level reference memory, and a per-cycle expected-output schedule
//   built from the access rules (WAIT+1 access cycles plus one turnaround
//   per accessed half, then one response cycle).
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 16;
  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 1;
  localparam int WORDS   = 1 << (ADDR_W - 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADDR_W-2:0]   req_addr;
  logic [3:0]          req_be;
  logic [2*DATA_W-1:0] req_wdata;
  logic                resp_valid;
  logic [2*DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0]   sram_addr;
  logic                sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  wire  [DATA_W-1:0]   sram_data;

  always #5 clk = ~clk;

  sram_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_WAIT (RD_WAIT),
    .WR_WAIT (WR_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .sram_data  (sram_data)
  );

  // ---------------- SRAM pin model and reference memory ----------------
  logic [15:0] sram_mem [0:2*WORDS-1];
  logic [31:0] ref_mem  [0:WORDS-1];
  logic        model_drive;
  logic [15:0] mem_rd;

  assign model_drive = (sram_ce_n == 1'b0) && (sram_oe_n == 1'b0);
  assign mem_rd      = sram_mem[sram_addr];
  assign sram_data   = model_drive ? mem_rd : 16'bz;

  // ---------------- expected-output schedule ----------------
  typedef struct packed {
    logic        ready;
    logic        rv;
    logic        rd_upd;
    logic [4:0]  strb;    // {ce_n, oe_n, we_n, ub_n, lb_n}
    logic        drv;
    logic [18:0] addr;
    logic [15:0] dout;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [18:0] model_addr;
  logic [31:0] model_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  // Expand one accepted request into the cycles it must occupy.
  task automatic build(input logic we, input logic [17:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    exp_t        e;
    int          w;
    logic [1:0]  lanes;
    logic [31:0] t;
    w = we ? WR_WAIT : RD_WAIT;
    e = '0;
    for (int h = 0; h < 2; h++) begin
      lanes = (h == 1) ? be[3:2] : be[1:0];
      if (!(we && lanes == 2'b00)) begin
        for (int k = 0; k <= w; k++) begin
          e      = '0;
          e.addr = {a, h[0]};
          e.dout = (h == 1) ? wd[31:16] : wd[15:0];
          if (we) begin
            e.strb = {1'b0, 1'b1, 1'b0, ~lanes[1], ~lanes[0]};
            e.drv  = 1'b1;
          end else begin
            e.strb = 5'b00100;
          end
          exp_q.push_back(e);
        end
        e.strb = 5'b11111;   // turnaround: write data still driven
        exp_q.push_back(e);
        model_addr = e.addr;
      end
    end
    e        = '0;
    e.strb   = 5'b11111;
    e.addr   = model_addr;
    e.rv     = 1'b1;
    e.rd_upd = !we;
    e.rdata  = ref_mem[a];
    exp_q.push_back(e);
    if (we) begin
      t = ref_mem[a];
      for (int b = 0; b < 4; b++) if (be[b]) t[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a] = t;
    end
  endtask

  // Advances the schedule and applies SRAM writes at each rising edge.
  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        model_addr  = '0;
        model_rdata = '0;
      end else begin
        if (!sram_ce_n && !sram_we_n) begin
          if (!sram_lb_n) sram_mem[sram_addr][7:0]  = sram_data[7:0];
          if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_data[15:8];
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        else if (req_valid) build(req_we, req_addr, req_be, req_wdata);
      end
    end
  endtask

  // Checks every output on every cycle against the schedule.
  task automatic compare_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() != 0) begin
          e = exp_q[0];
        end else begin
          e       = '0;
          e.ready = 1'b1;
          e.strb  = 5'b11111;
          e.addr  = model_addr;
        end
        if (e.rv && e.rd_upd) model_rdata = e.rdata;
        check("req_ready",  32'(req_ready),  32'(e.ready));
        check("resp_valid", 32'(resp_valid), 32'(e.rv));
        check("resp_rdata", resp_rdata,      model_rdata);
        check("sram_addr",  32'(sram_addr),  32'(e.addr));
        check("strobes",    32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}),
              32'(e.strb));
        check("bus_drive",  32'(dut.u_io_buf.oe), 32'(e.drv));
        if (e.drv) check("bus_data", 32'(sram_data), 32'(e.dout));
      end
    end
  endtask

  // Issue one request and wait for its response; lat counts cycles from
  // the acceptance edge to the cycle in which resp_valid is high.
  task automatic do_req(input logic we, input logic [17:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_be    = be;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("accept_timeout");
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      fail_now("resp_timeout");
      lat = -1;
    end
    rd = resp_rdata;
  endtask

  int          lat;
  int          n;
  logic [31:0] rd;
  logic [31:0] old_word;
  logic [17:0] ra;
  logic [3:0]  rbe;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    model_addr  = '0;
    model_rdata = '0;
    for (int i = 0; i < 2 * WORDS; i++) sram_mem[i] = 16'(i * 40503 + 4660);
    sram_mem[19'h100] = 16'h1234;
    sram_mem[19'h101] = 16'hABCD;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = {sram_mem[2*i+1], sram_mem[2*i]};

    fork
      model_loop();
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready",   32'(req_ready),  32'd1);
    check("rst_rvalid",  32'(resp_valid), 32'd0);
    check("rst_rdata",   resp_rdata,      32'd0);
    check("rst_addr",    32'(sram_addr),  32'd0);
    check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);

    // Two-half read
    do_req(1'b0, 18'h80, 4'b0000, 32'h0, lat, rd);
    check("rd_latency", 32'(lat), 32'd7);
    check("rd_data",    rd,       32'hABCD1234);

    // Full-word write
    do_req(1'b1, 18'h10, 4'b1111, 32'hDEADBEEF, lat, rd);
    check("wr_latency", 32'(lat), 32'd7);
    check("wr_lo_mem",  32'(sram_mem[19'h20]), 32'h0000BEEF);
    check("wr_hi_mem",  32'(sram_mem[19'h21]), 32'h0000DEAD);

    // Single byte in the high half
    do_req(1'b1, 18'h10, 4'b0100, 32'h00550000, lat, rd);
    check("wr1_latency", 32'(lat), 32'd4);
    check("wr1_hi_mem",  32'(sram_mem[19'h21]), 32'h0000DE55);
    check("wr1_lo_mem",  32'(sram_mem[19'h20]), 32'h0000BEEF);

    // Write with no bytes enabled
    do_req(1'b1, 18'h10, 4'b0000, 32'h12345678, lat, rd);
    check("wr0_latency", 32'(lat), 32'd1);
    @(negedge clk);
    check("wr0_ready_back", 32'(req_ready), 32'd1);
    check("wr0_mem", {16'(sram_mem[19'h21]), 16'(sram_mem[19'h20])}, 32'hDE55BEEF);

    // Back-to-back reads with req_valid held high
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 18'h80;
    req_be    = 4'b0000;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("b2b_accept_timeout");
    @(negedge clk);
    req_addr = 18'h10;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency1", 32'(lat), 32'd7);
    check("b2b_data1",    resp_rdata, 32'hABCD1234);
    check("b2b_ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency2", 32'(lat), 32'd7);
    check("b2b_data2",    resp_rdata, 32'hDE55BEEF);

    // Reset during the high-half access of a write. The high half carries
    // the word's current contents, so only the low half must change.
    old_word = ref_mem[18'h40];
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 18'h40;
    req_be    = 4'b1111;
    req_wdata = {old_word[31:16], 16'h7E57};
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_hi_acc", 32'(sram_addr), 32'h81);
    #1 rst_n = 1'b0;
    #1;
    check("abort_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
    check("abort_bus",     32'(dut.u_io_buf.oe), 32'd0);
    check("abort_rvalid",  32'(resp_valid), 32'd0);
    @(negedge clk);
    check("abort_rvalid_hold", 32'(resp_valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    do_req(1'b0, 18'h40, 4'b0000, 32'h0, lat, rd);
    check("abort_readback", rd, {old_word[31:16], 16'h7E57});

    // Randomized traffic over a small low window and the top of the space
    for (int t = 0; t < 150; t++) begin
      ra  = ($urandom_range(0, 3) == 0) ? 18'(18'h3FFF0 + $urandom_range(0, 15))
                                        : 18'($urandom_range(0, 31));
      rbe = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      do_req(1'($urandom), ra, rbe, $urandom, lat, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int w = 0; w < 32; w++)
      check("mem_low", {sram_mem[2*w+1], sram_mem[2*w]}, ref_mem[w]);
    for (int w = WORDS - 16; w < WORDS; w++)
      check("mem_top", {sram_mem[2*w+1], sram_mem[2*w]}, ref_mem[w]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
